qdrc_cal_sequencer: RTL and testbench
=====================================

// Module: qdrc_cal_sequencer
// PURPOSE
//  Top-level calibration sequencer for the QDR PHY. Holds the PHY align logic in reset, waits for
//  SRAM/DLL settle, then runs bit alignment followed by burst alignment. Retries on failure and
//  reports final pass/fail. phy_ready gates the user datapath mux (1 = user owns QDR bus).
// PARAMETERS
//  RST_CYCLES        16      clk0 cycles phy_rst is held high per attempt (>=1)
//  INIT_WAIT_CYCLES  2048    settle wait after phy_rst release before bit_align_start (0 legal)
//  TIMEOUT_CYCLES    65535   per-phase watchdog limit (used only with QDRC_CAL_TIMEOUT_EN)
//  MAX_RETRY         3       retries after first failed attempt; 0 = no retry
//  RETRY_W           2       width of retry_count (must hold MAX_RETRY)
// PORTS
//  clk0               in   1        sole clock
//  reset_n            in   1        asynchronous active-low reset
//  cal_start          in   1        pulse/level; sampled only in IDLE, DONE, FAIL
//  phy_rst            out  1        active-high sync reset to bit/burst align blocks
//  bit_align_start    out  1        one-cycle start pulse
//  bit_align_done     in   1        level, stays high once done
//  bit_align_fail     in   1        valid when bit_align_done=1
//  burst_align_start  out  1        one-cycle start pulse
//  burst_align_done   in   1        level
//  burst_align_fail   in   1        valid when burst_align_done=1
//  cal_done           out  1        calibration passed (level)
//  cal_fail           out  1        calibration exhausted retries (level)
//  cal_timeout        out  1        sticky: any phase hit watchdog this calibration run
//  phy_ready          out  1        = cal_done; selects user path in QDR mux
//  retry_count        out  RETRY_W  retries consumed this run
//  cal_state_prb      out  4        current state encoding (debug)
// BEHAVIOUR
//  All outputs registered. Reset values: phy_rst=1, every other output 0, state=IDLE.
//  States: IDLE, PHY_RST, INIT_WAIT, BIT_ALIGN, BURST_ALIGN, RETRY, DONE, FAIL.
//  IDLE: phy_rst=1; cal_start -> PHY_RST, retry_count<=0, cal_timeout<=0, timer<=RST_CYCLES.
//  PHY_RST: phy_rst=1 exactly RST_CYCLES cycles -> INIT_WAIT, timer<=INIT_WAIT_CYCLES.
//  INIT_WAIT: phy_rst=0; timer==0 -> bit_align_start=1 for one cycle, -> BIT_ALIGN.
//   INIT_WAIT_CYCLES=0: pulse issued on first INIT_WAIT cycle.
//  BIT_ALIGN: done&fail -> RETRY; done&!fail -> burst_align_start one cycle, -> BURST_ALIGN.
//  BURST_ALIGN: done&fail -> RETRY; done&!fail -> DONE.
//  RETRY: retry_count==MAX_RETRY -> FAIL; else retry_count+1, -> PHY_RST (timer reload).
//  DONE: cal_done=phy_ready=1, phy_rst=0. FAIL: cal_fail=1, phy_rst=1.
//  DONE/FAIL + cal_start: clear cal_done/cal_fail/retry_count/cal_timeout the next cycle, -> PHY_RST.
//  cal_start outside IDLE/DONE/FAIL ignored (no queueing).
//  done and fail same cycle -> failure. Start pulses never overlap; never two pulses per attempt.
//  Counter width = clog2(max(RST_CYCLES,INIT_WAIT_CYCLES,TIMEOUT_CYCLES)+1); no wrap, saturates at 0.
//  Async reset mid-run: immediate return to reset values regardless of state.
// CONFIGURATION
//  QDRC_CAL_TIMEOUT_EN defined: timer loads TIMEOUT_CYCLES on entry to BIT_ALIGN/BURST_ALIGN;
//   expiry with no done -> cal_timeout<=1, -> RETRY. done on expiry cycle wins (judged on fail).
//  Undefined: phases wait indefinitely; cal_timeout tied 0; TIMEOUT_CYCLES excluded from width.
// STRUCTURE
//  qdrc_pkg: state encodings (4-bit localparams), shared with the align-block probe decoders.
//  Sub-module qdrc_cal_timer: load value/load strobe, down-counter, zero flag; one instance
//   serves reset, init-wait and watchdog timing.
// TESTING
//  RST=4, INIT=8, both aligns pass 3 cycles after start -> phy_rst high 4 cycles, bit start 8 later, cal_done=1, retry_count=0.
//  bit_align fail on attempt 1, pass on attempt 2 -> second phy_rst pulse, retry_count=1, cal_done=1.
//  MAX_RETRY=0, burst_align fails -> cal_fail=1 immediately after RETRY, phy_rst=1, cal_done=0.
//  TIMEOUT_EN, TIMEOUT=100, burst_align_done never -> RETRY after 100 cycles, cal_timeout=1; done on cycle 100 -> DONE.
//  reset_n low during BIT_ALIGN -> same cycle phy_rst=1, starts=0, cal_state_prb=IDLE; cal_start in BIT_ALIGN ignored.
//  cal_start in DONE -> cal_done drops, full re-run with retry_count cleared, cal_done reasserts.

Source files
------------

// File: rtl/qdrc_pkg.sv
// qdrc_pkg: calibration sequencer state encodings and counter sizing helper.
// The 4-bit encodings are also decoded by the align-block probes, so keep them stable.
package qdrc_pkg;

  localparam logic [3:0] CAL_ST_IDLE        = 4'd0;
  localparam logic [3:0] CAL_ST_PHY_RST     = 4'd1;
  localparam logic [3:0] CAL_ST_INIT_WAIT   = 4'd2;
  localparam logic [3:0] CAL_ST_BIT_ALIGN   = 4'd3;
  localparam logic [3:0] CAL_ST_BURST_ALIGN = 4'd4;
  localparam logic [3:0] CAL_ST_RETRY       = 4'd5;
  localparam logic [3:0] CAL_ST_DONE        = 4'd6;
  localparam logic [3:0] CAL_ST_FAIL        = 4'd7;

  typedef enum logic [3:0] {
    ST_IDLE        = CAL_ST_IDLE,
    ST_PHY_RST     = CAL_ST_PHY_RST,
    ST_INIT_WAIT   = CAL_ST_INIT_WAIT,
    ST_BIT_ALIGN   = CAL_ST_BIT_ALIGN,
    ST_BURST_ALIGN = CAL_ST_BURST_ALIGN,
    ST_RETRY       = CAL_ST_RETRY,
    ST_DONE        = CAL_ST_DONE,
    ST_FAIL        = CAL_ST_FAIL
  } cal_state_e;

  // Watchdog span only widens the counter when the watchdog is built in.
  function automatic int unsigned cal_cnt_width(input int unsigned rst_cyc,
                                                input int unsigned init_cyc,
                                                input int unsigned to_cyc,
                                                input bit          use_to);
    int unsigned span;
    span = (rst_cyc > init_cyc) ? rst_cyc : init_cyc;
    if (use_to && (to_cyc > span)) span = to_cyc;
    return (span < 1) ? 1 : $clog2(span + 1);
  endfunction

endpackage

// File: rtl/qdrc_cal_timer.sv
// qdrc_cal_timer: loadable down-counter that stops at zero; shared by the reset,
// settle and watchdog intervals of the calibration sequencer.
module qdrc_cal_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk0,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/qdrc_cal_sequencer.sv
// qdrc_cal_sequencer: QDR PHY calibration sequencer (reset, settle, bit align, burst align, retry).
// Build option QDRC_CAL_TIMEOUT_EN adds a per-phase watchdog on the align phases.
//
// state       | meaning
// IDLE        | out of reset, align blocks held in reset, waiting for cal_start
// PHY_RST     | phy_rst asserted for RST_CYCLES
// INIT_WAIT   | SRAM/DLL settle before bit alignment
// BIT_ALIGN   | bit alignment running
// BURST_ALIGN | burst alignment running
// RETRY       | attempt failed; start another attempt or give up
// DONE        | calibrated, user datapath owns the QDR bus
// FAIL        | retries exhausted, align blocks held in reset
module qdrc_cal_sequencer
  import qdrc_pkg::*;
#(
  parameter int unsigned RST_CYCLES       = 16,
  parameter int unsigned INIT_WAIT_CYCLES = 2048,
  parameter int unsigned TIMEOUT_CYCLES   = 65535,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned RETRY_W          = 2
) (
  input  logic               clk0,
  input  logic               reset_n,
  input  logic               cal_start,
  output logic               phy_rst,
  output logic               bit_align_start,
  input  logic               bit_align_done,
  input  logic               bit_align_fail,
  output logic               burst_align_start,
  input  logic               burst_align_done,
  input  logic               burst_align_fail,
  output logic               cal_done,
  output logic               cal_fail,
  output logic               cal_timeout,
  output logic               phy_ready,
  output logic [RETRY_W-1:0] retry_count,
  output logic [3:0]         cal_state_prb
);

`ifdef QDRC_CAL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = cal_cnt_width(RST_CYCLES, INIT_WAIT_CYCLES, TIMEOUT_CYCLES, TO_EN);

  // Loads are interval-1 so the zero flag marks the last cycle of the interval.
  localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'((INIT_WAIT_CYCLES > 0) ? (INIT_WAIT_CYCLES - 1) : 0);
`ifdef QDRC_CAL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LD_TO   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  cal_state_e         state, state_nxt;
  logic               tmr_load, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;
  logic               bit_start_nxt, burst_start_nxt;
  logic [RETRY_W-1:0] retry_nxt;
`ifdef QDRC_CAL_TIMEOUT_EN
  logic               timeout_nxt;
`endif

  qdrc_cal_timer #(.W(CNT_W)) u_timer (
    .clk0     (clk0),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    tmr_load        = 1'b0;
    tmr_val         = '0;
    bit_start_nxt   = 1'b0;
    burst_start_nxt = 1'b0;
    retry_nxt       = retry_count;
`ifdef QDRC_CAL_TIMEOUT_EN
    timeout_nxt     = cal_timeout;
`endif
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (cal_start) begin
          state_nxt = ST_PHY_RST;
          tmr_load  = 1'b1;
          tmr_val   = LD_RST;
          retry_nxt = '0;
`ifdef QDRC_CAL_TIMEOUT_EN
          timeout_nxt = 1'b0;
`endif
        end
      end
      ST_PHY_RST: begin
        if (tmr_zero) begin
          state_nxt = ST_INIT_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = LD_INIT;
        end
      end
      ST_INIT_WAIT: begin
        if (tmr_zero) begin
          state_nxt     = ST_BIT_ALIGN;
          bit_start_nxt = 1'b1;
`ifdef QDRC_CAL_TIMEOUT_EN
          tmr_load      = 1'b1;
          tmr_val       = LD_TO;
`endif
        end
      end
      ST_BIT_ALIGN: begin
        if (bit_align_done) begin
          if (bit_align_fail) begin
            state_nxt = ST_RETRY;
          end else begin
            state_nxt       = ST_BURST_ALIGN;
            burst_start_nxt = 1'b1;
`ifdef QDRC_CAL_TIMEOUT_EN
            tmr_load        = 1'b1;
            tmr_val         = LD_TO;
`endif
          end
        end
`ifdef QDRC_CAL_TIMEOUT_EN
        else if (tmr_zero) begin
          state_nxt   = ST_RETRY;
          timeout_nxt = 1'b1;
        end
`endif
      end
      ST_BURST_ALIGN: begin
        if (burst_align_done) begin
          state_nxt = burst_align_fail ? ST_RETRY : ST_DONE;
        end
`ifdef QDRC_CAL_TIMEOUT_EN
        else if (tmr_zero) begin
          state_nxt   = ST_RETRY;
          timeout_nxt = 1'b1;
        end
`endif
      end
      ST_RETRY: begin
        if (retry_count == RETRY_W'(MAX_RETRY)) begin
          state_nxt = ST_FAIL;
        end else begin
          state_nxt = ST_PHY_RST;
          retry_nxt = retry_count + RETRY_W'(1);
          tmr_load  = 1'b1;
          tmr_val   = LD_RST;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with cal_state_prb.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      phy_rst           <= 1'b1;
      bit_align_start   <= 1'b0;
      burst_align_start <= 1'b0;
      cal_done          <= 1'b0;
      cal_fail          <= 1'b0;
      phy_ready         <= 1'b0;
      retry_count       <= '0;
    end else begin
      phy_rst           <= (state_nxt == ST_IDLE) || (state_nxt == ST_PHY_RST) ||
                           (state_nxt == ST_FAIL);
      bit_align_start   <= bit_start_nxt;
      burst_align_start <= burst_start_nxt;
      cal_done          <= (state_nxt == ST_DONE);
      cal_fail          <= (state_nxt == ST_FAIL);
      phy_ready         <= (state_nxt == ST_DONE);
      retry_count       <= retry_nxt;
    end
  end

`ifdef QDRC_CAL_TIMEOUT_EN
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) cal_timeout <= 1'b0;
    else          cal_timeout <= timeout_nxt;
  end
`else
  assign cal_timeout = 1'b0;
`endif

  assign cal_state_prb = state;

endmodule

// File: tb/tb_qdrc_cal_sequencer.sv
// tb_qdrc_cal_sequencer: two sequencer instances (default-ish and boundary parameters)
// driven by behavioural align-block responders and checked against a timeline model.
module tb_qdrc_cal_sequencer;
  import qdrc_pkg::*;

`ifdef QDRC_CAL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int R0 = 4, I0 = 8, T0 = 100, MR0 = 2;
  localparam int R1 = 1, I1 = 0, T1 = 20,  MR1 = 0;
  localparam int R_P  [2] = '{R0, R1};
  localparam int I_P  [2] = '{I0, I1};
  localparam int T_P  [2] = '{T0, T1};
  localparam int MR_P [2] = '{MR0, MR1};

  logic clk0 = 1'b0;
  logic reset_n;
  logic cal_start [2];
  logic bit_done [2], bit_fail [2], burst_done [2], burst_fail [2];
  logic phy_rst [2], bit_start [2], burst_start [2];
  logic cal_done [2], cal_fail [2], cal_timeout [2], phy_ready [2];
  logic [3:0] prb [2];
  logic [1:0] retry0;
  logic       retry1;

  int total = 0;
  int bad   = 0;

  // Per-attempt align behaviour: latency in cycles after start (0 = never answers), fail flag.
  int s_blat [4];
  bit s_bfail [4];
  int s_ulat [4];
  bit s_ufail [4];

  always #5 clk0 = ~clk0;

  qdrc_cal_sequencer #(
    .RST_CYCLES(R0), .INIT_WAIT_CYCLES(I0), .TIMEOUT_CYCLES(T0), .MAX_RETRY(MR0), .RETRY_W(2)
  ) u_dut0 (
    .clk0(clk0), .reset_n(reset_n), .cal_start(cal_start[0]), .phy_rst(phy_rst[0]),
    .bit_align_start(bit_start[0]), .bit_align_done(bit_done[0]), .bit_align_fail(bit_fail[0]),
    .burst_align_start(burst_start[0]), .burst_align_done(burst_done[0]),
    .burst_align_fail(burst_fail[0]), .cal_done(cal_done[0]), .cal_fail(cal_fail[0]),
    .cal_timeout(cal_timeout[0]), .phy_ready(phy_ready[0]), .retry_count(retry0),
    .cal_state_prb(prb[0])
  );

  qdrc_cal_sequencer #(
    .RST_CYCLES(R1), .INIT_WAIT_CYCLES(I1), .TIMEOUT_CYCLES(T1), .MAX_RETRY(MR1), .RETRY_W(1)
  ) u_dut1 (
    .clk0(clk0), .reset_n(reset_n), .cal_start(cal_start[1]), .phy_rst(phy_rst[1]),
    .bit_align_start(bit_start[1]), .bit_align_done(bit_done[1]), .bit_align_fail(bit_fail[1]),
    .burst_align_start(burst_start[1]), .burst_align_done(burst_done[1]),
    .burst_align_fail(burst_fail[1]), .cal_done(cal_done[1]), .cal_fail(cal_fail[1]),
    .cal_timeout(cal_timeout[1]), .phy_ready(phy_ready[1]), .retry_count(retry1),
    .cal_state_prb(prb[1])
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int get_rc(input int d);
    return (d == 0) ? int'(retry0) : int'(retry1);
  endfunction

  function automatic int eff_init(input int d);
    return (I_P[d] > 0) ? I_P[d] : 1;
  endfunction

  task automatic set_att(input int k, input int bl, input bit bf, input int ul, input bit uf);
    s_blat[k] = bl; s_bfail[k] = bf; s_ulat[k] = ul; s_ufail[k] = uf;
  endtask

  task automatic clr_align(input int d);
    bit_done[d] = 1'b0; bit_fail[d] = 1'b0; burst_done[d] = 1'b0; burst_fail[d] = 1'b0;
  endtask

  // One align phase: cycles it occupies and whether it ends the attempt.
  function automatic bit phase_fails(input int lat, input bit f, input int tmo,
                                     output int adv, output bit hung);
    hung = (lat == 0) || (TO_EN && (lat > tmo));
    adv  = hung ? tmo : lat;
    return hung || f;
  endfunction

  // Cycles from the cal_start edge to the edge that enters DONE/FAIL, plus final status.
  function automatic void model(input int d, output int dur, output bit done,
                                output int rc, output bit to);
    int t;
    t = 0; dur = 0; done = 1'b0; rc = 0; to = 1'b0;
    for (int k = 0; k <= MR_P[d]; k++) begin
      int adv;
      bit hung, failed;
      t += R_P[d] + eff_init(d);
      failed = phase_fails(s_blat[k], s_bfail[k], T_P[d], adv, hung);
      t += adv; to |= hung;
      if (!failed) begin
        failed = phase_fails(s_ulat[k], s_ufail[k], T_P[d], adv, hung);
        t += adv; to |= hung;
        if (!failed) begin
          dur = t; done = 1'b1; rc = k;
          return;
        end
      end
      t += 1;
      if (k == MR_P[d]) begin
        dur = t; rc = k;
        return;
      end
    end
  endfunction

  task automatic run_cal(input int d);
    int n, k, ki, att_start, fall_n, bcnt, ucnt, bstarts, exp_dur, exp_rc;
    bit exp_done, exp_to, prev_rst, fin, bfl, ufl;
    model(d, exp_dur, exp_done, exp_rc, exp_to);
    @(negedge clk0);
    prev_rst     = phy_rst[d];
    cal_start[d] = 1'b1;
    @(posedge clk0); #1;
    cal_start[d] = 1'b0;
    chk_eq("start_prb", prb[d], CAL_ST_PHY_RST);
    chk_eq("start_done_clr", cal_done[d], 0);
    chk_eq("start_fail_clr", cal_fail[d], 0);
    chk_eq("start_rc_clr", get_rc(d), 0);
    chk_eq("start_to_clr", cal_timeout[d], 0);
    n = 0; k = -1; att_start = 0; fall_n = 0; bcnt = 0; ucnt = 0; bstarts = 0;
    fin = 1'b0; bfl = 1'b0; ufl = 1'b0;
    while (!fin && n < 2000) begin
      if (phy_rst[d] && !prev_rst) att_start = n;
      if (!phy_rst[d] && prev_rst) begin
        chk_eq("rst_len", n - att_start, R_P[d]);
        fall_n = n; k++; bstarts = 0;
      end
      prev_rst = phy_rst[d];
      ki = (k < 0) ? 0 : ((k > 3) ? 3 : k);
      if (phy_rst[d]) begin
        clr_align(d); bcnt = 0; ucnt = 0;
      end
      if (bit_start[d]) begin
        chk_eq("init_gap", n - fall_n, eff_init(d));
        chk_eq("bit_start_once", bstarts, 0);
        bstarts++;
        bcnt = s_blat[ki]; bfl = s_bfail[ki];
      end
      if (burst_start[d]) begin
        chk_eq("start_overlap", bit_start[d], 0);
        ucnt = s_ulat[ki]; ufl = s_ufail[ki];
      end
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin bit_done[d] = 1'b1; bit_fail[d] = bfl; end
      end
      if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin burst_done[d] = 1'b1; burst_fail[d] = ufl; end
      end
      if (cal_done[d] || cal_fail[d]) fin = 1'b1;
      else begin
        @(posedge clk0); #1;
        n++;
      end
    end
    chk_eq("run_finished", fin, 1);
    chk_eq("run_latency", n, exp_dur);
    chk_eq("end_done", cal_done[d], exp_done);
    chk_eq("end_fail", cal_fail[d], !exp_done);
    chk_eq("end_ready", phy_ready[d], exp_done);
    chk_eq("end_phy_rst", phy_rst[d], !exp_done);
    chk_eq("end_rc", get_rc(d), exp_rc);
    chk_eq("end_timeout", cal_timeout[d], exp_to);
    chk_eq("end_prb", prb[d], exp_done ? CAL_ST_DONE : CAL_ST_FAIL);
  endtask

  task automatic rand_scn();
    for (int k = 0; k < 4; k++) begin
      s_blat[k]  = $urandom_range(5, 1);
      s_bfail[k] = ($urandom_range(2, 0) == 0);
      s_ulat[k]  = $urandom_range(5, 1);
      s_ufail[k] = ($urandom_range(2, 0) == 0);
      if (TO_EN && ($urandom_range(7, 0) == 0)) s_blat[k] = 0;
      if (TO_EN && ($urandom_range(7, 0) == 0)) s_ulat[k] = 0;
    end
  endtask

  // Start inst0 with a bit aligner that never answers; return at the first BIT_ALIGN cycle.
  task automatic hang_to_bit();
    int n;
    set_att(0, 0, 1'b0, 3, 1'b0);
    clr_align(0);
    @(negedge clk0);
    cal_start[0] = 1'b1;
    @(posedge clk0); #1;
    cal_start[0] = 1'b0;
    n = 0;
    while (prb[0] != CAL_ST_BIT_ALIGN && n < 100) begin
      @(posedge clk0); #1;
      n++;
    end
    chk_eq("reach_bit_align", prb[0], CAL_ST_BIT_ALIGN);
    chk_eq("bit_pulse_on_entry", bit_start[0], 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cal_start[d] = 1'b0;
      clr_align(d);
    end
    #23;
    for (int d = 0; d < 2; d++) begin
      chk_eq("rst_phy_rst", phy_rst[d], 1);
      chk_eq("rst_bit_start", bit_start[d], 0);
      chk_eq("rst_burst_start", burst_start[d], 0);
      chk_eq("rst_done", cal_done[d], 0);
      chk_eq("rst_fail", cal_fail[d], 0);
      chk_eq("rst_ready", phy_ready[d], 0);
      chk_eq("rst_timeout", cal_timeout[d], 0);
      chk_eq("rst_rc", get_rc(d), 0);
      chk_eq("rst_prb", prb[d], CAL_ST_IDLE);
    end
    @(negedge clk0) reset_n = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    chk_eq("idle_hold_prb", prb[0], CAL_ST_IDLE);
    chk_eq("idle_hold_phy_rst", phy_rst[0], 1);

    // clean pass from IDLE
    set_att(0, 3, 1'b0, 3, 1'b0);
    run_cal(0);
    // bit fails once, then passes (rerun from DONE)
    set_att(0, 3, 1'b1, 1, 1'b0);
    set_att(1, 3, 1'b0, 3, 1'b0);
    run_cal(0);
    // no retries allowed: burst failure goes straight to FAIL
    set_att(0, 2, 1'b0, 2, 1'b1);
    run_cal(1);
    // every attempt fails: retries exhausted
    for (int k = 0; k < 4; k++) set_att(k, 2, 1'b1, 2, 1'b0);
    run_cal(0);
`ifdef QDRC_CAL_TIMEOUT_EN
    // burst never answers, then answers exactly on the watchdog's last cycle
    set_att(0, 2, 1'b0, 0, 1'b0);
    set_att(1, 2, 1'b0, T0, 1'b0);
    run_cal(0);
`endif
    for (int i = 0; i < 14; i++) begin
      rand_scn();
      run_cal(i % 2);
    end

    // cal_start while aligning is ignored
    hang_to_bit();
    @(negedge clk0) cal_start[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk0); #1;
      chk_eq("ign_prb", prb[0], CAL_ST_BIT_ALIGN);
      chk_eq("ign_phy_rst", phy_rst[0], 0);
      chk_eq("ign_bit_start", bit_start[0], 0);
    end
    cal_start[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk_eq("arst_phy_rst", phy_rst[0], 1);
    chk_eq("arst_prb", prb[0], CAL_ST_IDLE);
    @(negedge clk0) reset_n = 1'b1;

    // async reset in the very cycle bit_align_start is high
    hang_to_bit();
    #1 reset_n = 1'b0;
    #1;
    chk_eq("arst_pulse_phy_rst", phy_rst[0], 1);
    chk_eq("arst_pulse_bit_start", bit_start[0], 0);
    chk_eq("arst_pulse_prb", prb[0], CAL_ST_IDLE);
    chk_eq("arst_pulse_done", cal_done[0], 0);
    @(negedge clk0) reset_n = 1'b1;

    set_att(0, 4, 1'b0, 2, 1'b0);
    run_cal(0);
    set_att(0, 1, 1'b0, 1, 1'b0);
    run_cal(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
